// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 requester: FSM state encoding, PPROT bit
// positions and elaboration-time helpers for parameter checking and sizing.
package apb_pkg;

    // Two-bit state encoding; the fourth code is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // Bit positions inside PPROT.
    localparam int PPROT_PRIV      = 0;
    localparam int PPROT_NONSECURE = 1;
    localparam int PPROT_INSTR     = 2;

    // APB4 data buses are 8, 16 or 32 bits wide.
    function automatic bit data_width_legal(input int width);
        return (width == 8) || (width == 16) || (width == 32);
    endfunction

    // Width of a counter that must reach timeout-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts wait cycles and flags the last permitted
// cycle. A TIMEOUT_CYCLES of zero disables the flag entirely.
module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);
    localparam int LIMIT     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_WIDTH-1:0] LIMIT_CNT = CNT_WIDTH'(LIMIT);

    logic [CNT_WIDTH-1:0] cnt;

    // Count ACCESS wait cycles, saturating at the last permitted cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT_CNT);

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: accepts valid/ready requests from a local command source,
// runs SETUP/ACCESS on the APB bus with back-to-back chaining, and returns a
// one-cycle response pulse. A watchdog forces completion of stuck transfers.
module apb4_master
    import apb_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    // Request interface
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_write,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [STRB_WIDTH-1:0] i_req_strb,
    input  logic [2:0]            i_req_prot,
    // Response interface
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_slverr,
    output logic                  o_rsp_timeout,
    // APB4 requester port
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic [2:0]            PPROT,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
        $error("apb4_master: DATA_WIDTH must be 8, 16 or 32");
    end

    apb_state_e state;
    logic       wd_hit;
    logic       tmo_hit;
    logic       done;
    logic       accept;

    apb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .clear    (state == ST_SETUP),
        .enable   ((state == ST_ACCESS) && !done),
        .hit      (wd_hit)
    );

    // Completion and handshake decode; PREADY beats the watchdog when both fire.
    always_comb begin
        // NOTE: every signal here is assigned on every pass through the block,
        // so no storage (latch) is implied.
        tmo_hit     = wd_hit && !PREADY;
        done        = (state == ST_ACCESS) && (PREADY || tmo_hit);
        o_req_ready = i_reset_n && ((state == ST_IDLE) || done);
        accept      = i_req_valid && o_req_ready;
    end

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            PADDR         <= '0;
            PWRITE        <= 1'b0;
            PWDATA        <= '0;
            PSTRB         <= '0;
            PPROT         <= '0;
            PSELx         <= 1'b0;
            PENABLE       <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_slverr  <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so PWRITE below is still the
            // direction of the finishing transfer even if a new request loads.
            o_rsp_valid <= 1'b0;

            if (done) begin
                o_rsp_valid   <= 1'b1;
                o_rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                o_rsp_slverr  <= PREADY ? PSLVERR : 1'b1;
                o_rsp_timeout <= tmo_hit;
            end

            if (accept) begin
                // Only possible from IDLE or a completing ACCESS.
                state   <= ST_SETUP;
                PSELx   <= 1'b1;
                PENABLE <= 1'b0;
                PADDR   <= i_req_addr;
                PWRITE  <= i_req_write;
                PWDATA  <= i_req_wdata;
                PSTRB   <= i_req_write ? i_req_strb : '0;
                PPROT   <= i_req_prot;
            end else begin
                case (state)
                    ST_IDLE: begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                    ST_SETUP: begin
                        PENABLE <= 1'b1;
                        state   <= ST_ACCESS;
                    end
                    ST_ACCESS: begin
                        if (done) begin
                            PSELx   <= 1'b0;
                            PENABLE <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Bench for apb4_master (TIMEOUT_CYCLES=4): directed requests, a small slave
// model with programmable wait states, and a response scoreboard.
module tb_apb4_master;
    import apb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr;
    logic          i_req_write;
    logic [DW-1:0] i_req_wdata;
    logic [SW-1:0] i_req_strb;
    logic [2:0]    i_req_prot;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_slverr;
    logic          o_rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic          PSELx;
    logic          PENABLE;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb4_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_write  (i_req_write),
        .i_req_wdata  (i_req_wdata),
        .i_req_strb   (i_req_strb),
        .i_req_prot   (i_req_prot),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_slverr (o_rsp_slverr),
        .o_rsp_timeout(o_rsp_timeout),
        .PADDR        (PADDR),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PSTRB        (PSTRB),
        .PPROT        (PPROT),
        .PSELx        (PSELx),
        .PENABLE      (PENABLE),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
        int          cyc;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Per-cycle trace of handshake signals, indexed by the edge count.
    logic psel_h[1024];
    logic pen_h[1024];
    logic rdy_h[1024];

    // Expected APB request fields for the transfer in flight.
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_write;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;

    // Slave model configuration.
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;

    assign PRDATA  = slv_rdata;
    assign PSLVERR = slv_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Slave: PREADY rises after slv_waits ACCESS cycles; also trace PSELx/PENABLE.
    always @(negedge i_clk) begin
        if (cyc < 1024) begin
            psel_h[cyc] = PSELx;
            pen_h[cyc]  = PENABLE;
        end
        if (PSELx && PENABLE) begin
            PREADY = (acc_cnt == slv_waits);
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            acc_cnt = 0;
        end
    end

    // o_req_ready depends on PREADY combinationally, so sample it after the slave updates.
    always @(negedge i_clk) begin
        #1;
        if (cyc < 1024) rdy_h[cyc] = o_req_ready;
    end

    // Request fields must stay stable throughout ACCESS.
    always @(negedge i_clk) begin
        if (i_reset_n && PSELx && PENABLE) begin
            check("access_paddr", PADDR, e_addr);
            check("access_pwrite", 32'(PWRITE), 32'(e_write));
            check("access_pwdata", PWDATA, e_wdata);
            check("access_pstrb", 32'(PSTRB), 32'(e_strb));
            check("access_pprot", 32'(PPROT), 32'(e_prot));
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge i_clk) begin
        if (o_rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got o_rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", o_rsp_rdata, mon_e.rdata);
                check("rsp_slverr", 32'(o_rsp_slverr), 32'(mon_e.slverr));
                check("rsp_timeout", 32'(o_rsp_timeout), 32'(mon_e.tmo));
                check("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Present a request (caller is just past a rising edge) and wait for acceptance.
    // lat is the expected number of edges from acceptance to the response pulse.
    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input logic want_rsp,
                        input logic [31:0] x_rdata, input logic x_err, input logic x_tmo,
                        input int lat, output int acc);
        logic rdy;
        acc         = -1;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_write = wr;
        i_req_wdata = wdata;
        i_req_strb  = strb;
        i_req_prot  = prot;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            #1 rdy = o_req_ready;
            @(posedge i_clk);
            #1;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no acceptance expected o_req_ready within 50 cycles");
        end else begin
            e_addr  = addr;
            e_write = wr;
            e_wdata = wdata;
            e_strb  = wr ? strb : 4'h0;
            e_prot  = prot;
            if (want_rsp) sb.push_back('{x_rdata, x_err, x_tmo, acc + lat});
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(posedge i_clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_timeout: got %0d pending expected 0 pending", sb.size());
            sb.delete();
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"}, 32'(PSELx), 0);
        check({tag, "_penable"}, 32'(PENABLE), 0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_pstrb"}, 32'(PSTRB), 0);
        check({tag, "_pprot"}, 32'(PPROT), 0);
        check({tag, "_pwrite"}, 32'(PWRITE), 0);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 0);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, 0);
        check({tag, "_rsp_slverr"}, 32'(o_rsp_slverr), 0);
        check({tag, "_rsp_timeout"}, 32'(o_rsp_timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        i_reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_write = 1'b0;
        i_req_wdata = '0;
        i_req_strb  = '0;
        i_req_prot  = '0;
        PREADY      = 1'b0;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check_all_zero("reset");
        check("reset_ready", 32'(o_req_ready), 0);
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(negedge i_clk);
        #1 check("idle_ready", 32'(o_req_ready), 1);
        @(posedge i_clk);
        #1;

        // Write, zero wait states
        slv_waits = 0;
        slv_err   = 1'b0;
        send(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'(1 << PPROT_PRIV),
             1'b1, 32'h0, 1'b0, 1'b0, 2, a);
        i_req_valid = 1'b0;
        wait_rsp();
        check("wr_psel_before", 32'(psel_h[a-1]), 0);
        check("wr_psel_setup", 32'(psel_h[a]), 1);
        check("wr_pen_setup", 32'(pen_h[a]), 0);
        check("wr_pen_access", 32'(pen_h[a+1]), 1);
        check("wr_psel_after", 32'(psel_h[a+2]), 0);

        // Read, 3 wait states: PREADY lands on the 4th ACCESS cycle, beating the watchdog
        slv_waits = 3;
        slv_rdata = 32'h1234_5678;
        send(32'h0000_0020, 1'b0, 32'hA5A5_A5A5, 4'hF, 3'(1 << PPROT_NONSECURE),
             1'b1, 32'h1234_5678, 1'b0, 1'b0, 5, a);
        i_req_valid = 1'b0;
        wait_rsp();
        for (int i = 1; i <= 4; i++) check("rd_wait_penable", 32'(pen_h[a+i]), 1);
        check("rd_psel_after", 32'(psel_h[a+5]), 0);
        check("rd_rdata_held", o_rsp_rdata, 32'h1234_5678);

        // Back-to-back writes
        slv_waits = 0;
        send(32'h0000_0030, 1'b1, 32'h1111_1111, 4'h3, 3'h0, 1'b1, 32'h0, 1'b0, 1'b0, 2, a);
        send(32'h0000_0034, 1'b1, 32'h2222_2222, 4'hC, 3'h0, 1'b1, 32'h0, 1'b0, 1'b0, 2, b);
        i_req_valid = 1'b0;
        wait_rsp();
        check("b2b_accept_gap", b - a, 2);
        for (int i = 0; i < 4; i++) begin
            check("b2b_psel", 32'(psel_h[a+i]), 1);
            check("b2b_penable", 32'(pen_h[a+i]), 32'(i % 2));
        end
        check("b2b_ready_done1", 32'(rdy_h[a+1]), 1);
        check("b2b_ready_done2", 32'(rdy_h[a+3]), 1);

        // Slave error on a read
        slv_err   = 1'b1;
        slv_rdata = 32'hCAFE_F00D;
        send(32'h0000_0050, 1'b0, 32'h0, 4'h0, 3'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 2, a);
        i_req_valid = 1'b0;
        wait_rsp();
        slv_err = 1'b0;

        // Watchdog timeout: slave never answers
        slv_waits = 99;
        send(32'h0000_0040, 1'b0, 32'h0, 4'hF, 3'(1 << PPROT_INSTR),
             1'b1, 32'h0, 1'b1, 1'b1, 5, a);
        i_req_valid = 1'b0;
        wait_rsp();
        for (int i = 1; i <= 4; i++) check("tmo_access_cycles", 32'(pen_h[a+i]), 1);
        check("tmo_psel_after", 32'(psel_h[a+5]), 0);

        // Reset during an ACCESS wait state
        send(32'h0000_0060, 1'b0, 32'h5555_AAAA, 4'h0, 3'h7, 1'b0, 32'h0, 1'b0, 1'b0, 0, a);
        i_req_valid = 1'b0;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1 i_reset_n = 1'b0;
        @(negedge i_clk);
        #1 check("rst_mid_ready", 32'(o_req_ready), 0);
        @(posedge i_clk);
        #1;
        check_all_zero("rst_mid");
        i_reset_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;

        // A fresh read after reset
        slv_waits = 1;
        slv_rdata = 32'h0BAD_C0DE;
        send(32'h0000_0070, 1'b0, 32'h0, 4'hF, 3'h0, 1'b1, 32'h0BAD_C0DE, 1'b0, 1'b0, 3, a);
        i_req_valid = 1'b0;
        wait_rsp();

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- Parametrised APB4 requester. Supersedes the single-shot 32-bit APB master.
- Adds a valid/ready request interface and back-to-back transfers (no IDLE cycle between them).
- Adds APB4 PSTRB/PPROT, a PREADY watchdog timeout, and a one-cycle response pulse.
- Sits between a local command source (CPU bridge or DMA) and an APB slave.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and request address.
- DATA_WIDTH, 32, data width; legal values 8/16/32; STRB_WIDTH = DATA_WIDTH/8 (localparam).
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before forced termination; 0 disables the watchdog.
- CNT_WIDTH, derived as $clog2(TIMEOUT_CYCLES+1), minimum 1 (localparam).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  request accepted when valid&&ready.
- i_req_addr  input  ADDR_WIDTH  transfer address.
- i_req_write  input  1  1=write, 0=read.
- i_req_wdata  input  DATA_WIDTH  write data.
- i_req_strb  input  STRB_WIDTH  byte lanes for writes.
- i_req_prot  input  3  PPROT value.
- o_rsp_valid  output  1  one-cycle completion pulse.
- o_rsp_rdata  output  DATA_WIDTH  read data; held until the next response.
- o_rsp_slverr  output  1  slave error or timeout.
- o_rsp_timeout  output  1  completion caused by the watchdog.
- PADDR  output  ADDR_WIDTH  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PSTRB  output  STRB_WIDTH  APB write strobes.
- PPROT  output  3  APB protection.
- PSELx  output  1  slave select.
- PENABLE  output  1  access phase.
- PRDATA  input  DATA_WIDTH  read data.
- PREADY  input  1  slave ready.
- PSLVERR  input  1  slave error.

Behaviour:
- Reset (i_reset_n=0 at a clock edge): all registered outputs go to 0 and the state goes to IDLE.
- Reset mid-transfer: the transfer is abandoned and no response is issued.
- States: IDLE, SETUP, ACCESS; 2-bit encoding; any unused encoding goes to IDLE.
- Completion event, comb: done = ACCESS && (PREADY || tmo_hit).
- tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES-1) && !PREADY.
- o_req_ready (combinational) = i_reset_n && (state==IDLE || done).
- Acceptance (valid&&ready) registers the request into the APB outputs and moves to SETUP.
  - On acceptance: PSELx=1, PENABLE=0.
  - PSTRB = i_req_write ? i_req_strb : 0. Read strobes are forced to zero.
  - PWDATA is loaded regardless of direction.
- IDLE, no acceptance: PSELx=0, PENABLE=0. PADDR/PWDATA/PSTRB/PPROT/PWRITE hold their last values.
- SETUP: next cycle PENABLE=1, state ACCESS, cnt=0. SETUP lasts exactly one cycle; i_req_* is ignored.
- ACCESS without done: all APB outputs stable; cnt increments, saturating at TIMEOUT_CYCLES-1.
- ACCESS with done, response:
  - o_rsp_valid=1 next cycle.
  - o_rsp_rdata = (PREADY && !PWRITE) ? PRDATA : 0.
  - o_rsp_slverr = PREADY ? PSLVERR : 1.
  - o_rsp_timeout = tmo_hit.
- ACCESS with done, next state:
  - If a request is accepted in the same cycle: state SETUP, PSELx stays 1, PENABLE=0, new request registered.
  - Otherwise: state IDLE, PSELx=0, PENABLE=0.
- PREADY and timeout in the same cycle: PREADY wins and the completion is normal.
- o_rsp_valid is deasserted on every cycle except the one after done.
- o_rsp_rdata/o_rsp_slverr/o_rsp_timeout hold their values between responses.
- Minimum latency from acceptance to o_rsp_valid: 3 cycles (SETUP, ACCESS with PREADY, response). Each PREADY wait cycle adds one.
- Back-to-back throughput: one transfer every 2 cycles.
- With TIMEOUT_CYCLES=N, a non-responding slave gets N ACCESS cycles; the response appears on cycle N+2 after acceptance.

Decomposition:
- Package apb_pkg:
  - State encoding localparams (IDLE/SETUP/ACCESS).
  - PPROT bit constants (PRIV=0, NONSECURE=1, INSTR=2).
  - DATA_WIDTH legality check (elaboration-time $error).
- Sub-module apb_watchdog (counter, clear/enable/hit; parameter TIMEOUT_CYCLES). This is the natural sub-module.
- FSM and datapath stay in apb4_master.

Test Plan:
- Write, zero wait: addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, PREADY=1.
  - -> PSELx rises at T+1, PENABLE at T+2, o_rsp_valid at T+3.
  - -> slverr=0, PSTRB=0xF during the transfer.
- Read with 3 wait states: PRDATA=0x1234_5678 when PREADY asserts.
  - -> o_rsp_rdata=0x1234_5678 at T+6.
  - -> PADDR/PENABLE stable throughout ACCESS; PSTRB=0 on the read even with i_req_strb=0xF.
- Back-to-back: hold i_req_valid with two writes, PREADY=1.
  - -> PSELx never drops, PENABLE pattern 0,1,0,1.
  - -> two responses 2 cycles apart; o_req_ready high in both completion cycles.
- Timeout, TIMEOUT_CYCLES=4, PREADY=0.
  - -> exactly 4 ACCESS cycles, then o_rsp_valid with slverr=1, timeout=1, rdata=0.
  - -> PSELx=0 afterwards.
  - Also: PREADY=1 on the 4th ACCESS cycle -> normal completion, timeout=0.
- PSLVERR=1 with PREADY=1 on a read -> o_rsp_slverr=1, o_rsp_timeout=0.
- Reset mid-ACCESS: drop i_reset_n during a wait state.
  - -> next cycle all outputs 0 and state IDLE, no o_rsp_valid.
  - -> after release, a new read completes normally.
